// File: rtl/dll_pkg.sv
// Shared definitions for the DLL code loop: FSM state encoding, datapath
// widths and integrator saturation limits.
package dll_pkg;

  localparam int DISC_W  = 9;
  localparam int INTEG_W = 24;
  localparam int CW_W    = 16;

  localparam logic signed [INTEG_W-1:0] INTEG_MAX = 24'sh7F_FFFF;
  localparam logic signed [INTEG_W-1:0] INTEG_MIN = -24'sh7F_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DISC,
    ST_FILT,
    ST_OUT
  } dll_state_e;

endpackage

// File: rtl/dll_code_loop_if.sv
// Epoch bundle from the early/late correlator dispatcher into the DLL.
// master = correlator side, slave = DLL side.
interface dll_code_loop_if;
  logic       rdy_in;
  logic [7:0] early_in;
  logic [7:0] late_in;

  modport master (output rdy_in, output early_in, output late_in);
  modport slave  (input  rdy_in, input  early_in, input  late_in);
endinterface

// File: rtl/dll_loop_filter.sv
// Proportional-integral loop filter. The integrator accumulates the
// discriminator when enabled and saturates instead of wrapping; the PI sum
// is clamped to +/-CORR_LIMIT. corr_o is combinational and is only
// meaningful while en_i is high (it already includes this epoch's update).
module dll_loop_filter
  import dll_pkg::*;
#(
  parameter int KP_SHIFT   = 2,
  parameter int KI_SHIFT   = 6,
  parameter int CORR_LIMIT = 256
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     en_i,
  input  logic signed [DISC_W-1:0] disc_i,
  output logic        [CW_W-1:0]   corr_o
);

  localparam logic signed [INTEG_W-1:0] CORR_MAX = INTEG_W'(CORR_LIMIT);
  localparam logic signed [INTEG_W-1:0] CORR_MIN = -CORR_MAX;

  logic signed [INTEG_W-1:0] integ_q, integ_d;
  logic signed [INTEG_W-1:0] p_term, i_term, pi_sum;

  function automatic logic signed [INTEG_W-1:0] sat_add(
    input logic signed [INTEG_W-1:0] acc,
    input logic signed [DISC_W-1:0]  d
  );
    logic signed [INTEG_W:0] s;
    s = $signed({acc[INTEG_W-1], acc}) + (INTEG_W+1)'(d);
    if (s > INTEG_MAX)      return INTEG_MAX;
    else if (s < INTEG_MIN) return INTEG_MIN;
    else                    return s[INTEG_W-1:0];
  endfunction

  function automatic logic [CW_W-1:0] clamp_corr(
    input logic signed [INTEG_W-1:0] c
  );
    if (c > CORR_MAX)      return CORR_MAX[CW_W-1:0];
    else if (c < CORR_MIN) return CORR_MIN[CW_W-1:0];
    else                   return c[CW_W-1:0];
  endfunction

  // next integrator value and clamped PI correction for this epoch
  always_comb begin
    integ_d = integ_q;
    if (en_i) integ_d = sat_add(integ_q, disc_i);
    p_term = INTEG_W'(disc_i) <<< KP_SHIFT;
    i_term = integ_d >>> KI_SHIFT;
    pi_sum = p_term + i_term;
    corr_o = clamp_corr(pi_sum);
  end

  // integrator register
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) integ_q <= '0;
    else         integ_q <= integ_d;
  end

endmodule

// File: rtl/dll_code_loop.sv
// DLL discriminator + loop filter top. Captures early/late magnitudes on an
// epoch strobe, forms E-L, runs the PI filter and publishes a registered
// code-NCO control word four cycles after the strobe.
// Optional lock detector enabled by defining DLL_LOCK_DETECT_EN.
module dll_code_loop
  import dll_pkg::*;
#(
  parameter logic [CW_W-1:0] CW_NOMINAL  = 16'h0400,
  parameter int              KP_SHIFT    = 2,
  parameter int              KI_SHIFT    = 6,
  parameter int              CORR_LIMIT  = 256,
  parameter int              LOCK_THRESH = 8,
  parameter int              LOCK_COUNT  = 16
) (
  input  logic                     clk,
  input  logic                     rst_in,
  dll_code_loop_if.slave           epoch,
  output logic        [CW_W-1:0]   control_word,
  output logic                     cw_valid,
  output logic signed [DISC_W-1:0] disc,
  output logic                     busy,
  output logic                     overrun,
  output logic                     locked
);

  dll_state_e state_q, state_d;

  logic        [7:0]        early_q, late_q;
  logic signed [DISC_W-1:0] disc_q, disc_d;
  logic        [CW_W-1:0]   cw_q, cw_d;
  logic                     cw_valid_q;
  logic                     overrun_q;
  logic        [CW_W-1:0]   corr;

  // FSM state register
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: one cycle per stage, IDLE waits for the epoch strobe
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (epoch.rdy_in) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_DISC;
      ST_DISC:    state_d = ST_FILT;
      ST_FILT:    state_d = ST_OUT;
      ST_OUT:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // correlator magnitudes are pure data; only an accepted strobe loads them
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && epoch.rdy_in) begin
      early_q <= epoch.early_in;
      late_q  <= epoch.late_in;
    end
  end

  // discriminator and output word candidates
  always_comb begin
    disc_d = $signed({1'b0, early_q}) - $signed({1'b0, late_q});
    cw_d   = CW_NOMINAL + corr;
  end

  // registered discriminator, control word, valid pulse and sticky overrun
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      disc_q     <= '0;
      cw_q       <= CW_NOMINAL;
      cw_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (state_q == ST_DISC) disc_q <= disc_d;
      if (state_q == ST_FILT) cw_q   <= cw_d;
      cw_valid_q <= (state_q == ST_FILT);
      if (epoch.rdy_in && state_q != ST_IDLE) overrun_q <= 1'b1;
    end
  end

  dll_loop_filter #(
    .KP_SHIFT   (KP_SHIFT),
    .KI_SHIFT   (KI_SHIFT),
    .CORR_LIMIT (CORR_LIMIT)
  ) u_filter (
    .clk    (clk),
    .rst_in (rst_in),
    .en_i   (state_q == ST_FILT),
    .disc_i (disc_q),
    .corr_o (corr)
  );

`ifdef DLL_LOCK_DETECT_EN
  localparam int LCW = $clog2(LOCK_COUNT + 1);

  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic              locked_q, locked_d;
  logic [DISC_W-1:0] disc_mag;

  // lock evaluation lands on the same edge as the control word update
  always_comb begin
    disc_mag   = disc_q[DISC_W-1] ? $unsigned(-disc_q) : $unsigned(disc_q);
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (state_q == ST_FILT) begin
      if (disc_mag <= DISC_W'(LOCK_THRESH)) begin
        if (lock_cnt_q != LCW'(LOCK_COUNT)) lock_cnt_d = lock_cnt_q + LCW'(1);
        locked_d = (lock_cnt_d == LCW'(LOCK_COUNT));
      end else begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end
    end
  end

  // lock counter and indicator registers
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  assign control_word = cw_q;
  assign cw_valid     = cw_valid_q;
  assign disc         = disc_q;
  assign busy         = (state_q != ST_IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_dll_code_loop.sv
// Bench for dll_code_loop: directed epochs plus randomized strobes checked
// against an epoch-level arithmetic model of the DLL loop.
module tb_dll_code_loop;

  logic               clk = 1'b0;
  logic               rst_in = 1'b0;
  logic [15:0]        control_word;
  logic               cw_valid;
  logic signed [8:0]  disc;
  logic               busy;
  logic               overrun;
  logic               locked;

  dll_code_loop_if ep ();

  dll_code_loop dut (
    .clk          (clk),
    .rst_in       (rst_in),
    .epoch        (ep.slave),
    .control_word (control_word),
    .cw_valid     (cw_valid),
    .disc         (disc),
    .busy         (busy),
    .overrun      (overrun),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state (epoch level)
  int          it;
  bit          pend;
  int          due;
  int          pe, pl;
  int          m_integ;
  int          m_disc;
  int          m_lcnt;
  bit          m_lock;
  bit          m_ovr;
  logic [15:0] m_cw;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int floor_div64(input int x);
    if (x >= 0) return x / 64;
    return -((-x + 63) / 64);
  endfunction

  function automatic int clip(input int x, input int lim);
    if (x > lim)  return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  // one completed epoch of the loop, straight from the arithmetic rules
  task automatic model_epoch(input int e, input int l);
    int d, c;
    d       = e - l;
    m_integ = clip(m_integ + d, 8388607);
    c       = clip(d * 4 + floor_div64(m_integ), 256);
    m_cw    = 16'(16'h0400 + c);
    m_disc  = d;
`ifdef DLL_LOCK_DETECT_EN
    if (d <= 8 && d >= -8) begin
      if (m_lcnt < 16) m_lcnt++;
    end else begin
      m_lcnt = 0;
    end
    m_lock = (m_lcnt == 16);
`else
    m_lock = 1'b0;
`endif
  endtask

  task automatic model_reset();
    pend    = 1'b0;
    m_integ = 0;
    m_disc  = 0;
    m_lcnt  = 0;
    m_lock  = 1'b0;
    m_ovr   = 1'b0;
    m_cw    = 16'h0400;
  endtask

  // one clock: check outputs at the falling edge, then drive the next inputs
  task automatic step(input bit r, input logic [7:0] e, input logic [7:0] l);
    bit exp_cwv, exp_busy;
    @(negedge clk);
    it++;
    exp_cwv = 1'b0;
    if (pend && it == due) begin
      model_epoch(pe, pl);
      pend    = 1'b0;
      exp_cwv = 1'b1;
    end
    exp_busy = pend || exp_cwv;
    chk("cw_valid", int'(cw_valid), int'(exp_cwv));
    chk("busy", int'(busy), int'(exp_busy));
    chk("overrun", int'(overrun), int'(m_ovr));
    chk("locked", int'(locked), int'(m_lock));
    chk("control_word", int'(control_word), int'(m_cw));
    if (!pend) chk("disc", int'(disc), m_disc);
    ep.rdy_in   = r;
    ep.early_in = e;
    ep.late_in  = l;
    if (r) begin
      if (!exp_busy) begin
        pend = 1'b1;
        due  = it + 4;
        pe   = int'(e);
        pl   = int'(l);
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0);
  endtask

  task automatic epoch_run(input logic [7:0] e, input logic [7:0] l);
    step(1'b1, e, l);
    idle(4);
  endtask

  task automatic reset_dut();
    rst_in    = 1'b0;
    ep.rdy_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cw_valid", int'(cw_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_control_word", int'(control_word), 16'h0400);
    chk("rst_disc", int'(disc), 0);
    model_reset();
    rst_in = 1'b1;
  endtask

  initial begin
    ep.rdy_in   = 1'b0;
    ep.early_in = 8'd0;
    ep.late_in  = 8'd0;
    it = 0;
    model_reset();

    // zero discriminator
    reset_dut();
    epoch_run(8'd100, 8'd100);
    idle(2);
    chk("tp_zero_cw", int'(control_word), 16'h0400);

    // proportional then integral contribution
    reset_dut();
    for (int i = 0; i < 4; i++) epoch_run(8'd120, 8'd100);
    idle(1);
    chk("tp_pi_cw", int'(control_word), 16'h0451);

    // positive and negative clamps
    reset_dut();
    epoch_run(8'd255, 8'd0);
    idle(1);
    chk("tp_clamp_pos", int'(control_word), 16'h0500);
    reset_dut();
    epoch_run(8'd0, 8'd255);
    idle(1);
    chk("tp_clamp_neg", int'(control_word), 16'h0300);

    // strobe while busy, then strobe on the first idle cycle
    reset_dut();
    step(1'b1, 8'd10, 8'd5);
    step(1'b0, 8'd0, 8'd0);
    step(1'b1, 8'd200, 8'd0);
    step(1'b0, 8'd0, 8'd0);
    step(1'b1, 8'd30, 8'd60);
    step(1'b1, 8'd90, 8'd60);
    idle(6);
    chk("tp_overrun_sticky", int'(overrun), 1);

    // lock acquisition then loss
    reset_dut();
    for (int i = 0; i < 16; i++) epoch_run(8'd50, 8'd50);
    idle(1);
    epoch_run(8'd60, 8'd50);
    idle(1);

    // reset during the filter cycle aborts the epoch and clears the integrator
    reset_dut();
    step(1'b1, 8'd200, 8'd100);
    idle(3);
    reset_dut();
    epoch_run(8'd77, 8'd77);
    idle(1);
    chk("tp_abort_cw", int'(control_word), 16'h0400);

    // randomized strobes, magnitudes and one reset mid-stream
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      bit          r;
      logic [7:0]  e, l;
      r = ($urandom_range(0, 99) < 35);
      e = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) l = 8'(int'(e) + $urandom_range(0, 8) - 4);
      else                           l = 8'($urandom_range(0, 255));
      step(r, e, l);
      if (i == 300) reset_dut();
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dll_code_loop.md
Name: dll_code_loop

Overview:
- Delay-lock-loop discriminator and loop filter. Sits directly downstream of the early/late correlator dispatcher.
- On each correlator epoch (`rdy` pulse) it captures the early and late 8-bit magnitudes and forms the E−L discriminator.
- A proportional-integral filter turns the discriminator into a saturated code-NCO frequency control word, which is fed back to the code NCOs.
- Optional lock detector flags sustained small discriminator error.

Parameters:
- CW_NOMINAL, 16'h0400, nominal code-NCO control word (zero-correction point).
- KP_SHIFT, 2, proportional gain as left shift of disc.
- KI_SHIFT, 6, integral gain as arithmetic right shift of integrator.
- CORR_LIMIT, 256, symmetric clamp on correction magnitude (±CORR_LIMIT).
- LOCK_THRESH, 8, |disc| ≤ this counts as an in-lock epoch.
- LOCK_COUNT, 16, consecutive in-lock epochs required to assert locked.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_in  in  1  asynchronous active-low reset.
- rdy_in  in  1  one-cycle epoch strobe from correlator.
- early_in  in  8  unsigned early correlator magnitude, valid when rdy_in=1.
- late_in  in  8  unsigned late correlator magnitude, valid when rdy_in=1.
- control_word  out  16  code-NCO control word, registered.
- cw_valid  out  1  one-cycle pulse when control_word updates.
- disc  out  9  signed E−L of last completed epoch.
- busy  out  1  high while FSM not in IDLE.
- overrun  out  1  sticky; rdy_in arrived while busy.
- locked  out  1  lock indicator (see Optional Feature).

Behaviour:
- Reset (rst_in=0, async): control_word=CW_NOMINAL; cw_valid, disc, busy, overrun and locked = 0; integrator=0; lock counter=0; FSM=IDLE.
- FSM states: IDLE → CAPTURE → DISC → FILT → OUT → IDLE; one cycle per state except IDLE.
- IDLE: on rdy_in=1, register early_in/late_in and go to CAPTURE.
- CAPTURE: go to DISC.
- DISC: disc = {0,E} − {0,L}, signed 9-bit, range −255..255.
- FILT:
  - integ (24-bit signed) += sign-extended disc, saturating at ±(2^23−1); never wraps.
  - corr = (disc <<< KP_SHIFT) + (integ >>> KI_SHIFT), computed in 24-bit signed.
  - corr is clamped to [−CORR_LIMIT, +CORR_LIMIT].
- OUT: control_word = CW_NOMINAL + corr[15:0] (modulo 16). cw_valid=1 for exactly this cycle. Return to IDLE.
- Latency: rdy_in high at cycle N → cw_valid high at cycle N+4. Minimum epoch spacing is 5 cycles.
- rdy_in while busy=1 is ignored: no capture, and overrun is set. overrun clears only on reset.
- rdy_in in the same cycle the FSM returns to IDLE (the OUT cycle) counts as busy and is ignored.
- Reset asserted mid-epoch aborts the epoch: no cw_valid, all state reset.
- control_word holds between updates.

Optional Feature:
- Macro: DLL_LOCK_DETECT_EN.
- Enabled: evaluated in OUT.
  - If |disc| ≤ LOCK_THRESH, the counter increments, saturating at LOCK_COUNT.
  - Otherwise counter=0 and locked=0.
  - locked=1 when counter==LOCK_COUNT, updating in the same cycle as cw_valid.
- Disabled: no counter; locked tied to 0.

Decomposition:
- Shared package dll_pkg:
  - FSM state enum (IDLE, CAPTURE, DISC, FILT, OUT);
  - widths DISC_W=9, INTEG_W=24, CW_W=16;
  - saturation constants INTEG_MAX/INTEG_MIN.
- One sub-module, dll_loop_filter: integrator register, PI sum and clamp, with enable from the FILT state. The top block holds the FSM, capture, discriminator and lock detector.

Test Plan:
- Reset, then rdy_in with E=100, L=100 → cw_valid 4 cycles later, disc=0, control_word=0x0400.
- From reset, 4 epochs of E=120, L=100 → control_word 0x0450, 0x0450, 0x0450, then 0x0451 (integ=80, 80>>>6=1).
- From reset, E=255, L=0 → control_word=0x0500 (clamped +256); from reset, E=0, L=255 → 0x0300 (clamped −256).
- rdy_in at cycles 0 and 2 → only one cw_valid (cycle 4) and overrun=1 persists. Next rdy_in at cycle 5 is accepted.
- With DLL_LOCK_DETECT_EN: 16 epochs of E=L=50 → locked=1 at 16th cw_valid. Then E=60, L=50 (disc=10) → locked=0 at that cw_valid. Without the macro, locked stays 0 throughout.
- rst_in low during the FILT cycle of an E=200, L=100 epoch → no cw_valid; control_word=0x0400; integ=0 (next E=L epoch yields 0x0400).
